// File: rtl/mips_16_arb_pkg.sv
// Shared types for the MIPS-16 data memory arbiter: FSM states and grant selector.
package mips_16_arb_pkg;

  typedef enum logic [1:0] {
    SHARE,
    DRAIN,
    HALT
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CORE,
    GNT_DBG
  } grant_t;

endpackage

// File: rtl/mips_16_arb_starve_cnt.sv
// Saturating count of consecutive cycles the debug port waited without a grant.
module mips_16_arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_reg;

  assign at_max = (cnt_reg == W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && !at_max) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mips_16_dmem_arbiter.sv
// Arbitrates the single-port data memory between the core MEM stage (priority)
// and a debug/loader port, with anti-starvation slots and a halt/drain handshake.
module mips_16_dmem_arbiter
  import mips_16_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt_req,
  output logic              dbg_halt_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_reg;
  grant_t            grant;
  logic              starve_at_max;
  logic              core_go;
  logic              dbg_go;
  logic              core_rd_pend_reg;
  logic              dbg_rd_pend_reg;
  logic [DATA_W-1:0] core_rdata_reg;
  logic [DATA_W-1:0] dbg_rdata_reg;

  // Grant is forced to none while reset is held so every output reads 0.
  always_comb begin
    grant = GNT_NONE;
    if (rst) begin
      case (state_reg)
        SHARE: begin
          if (core_req && !(dbg_valid && starve_at_max)) begin
            grant = GNT_CORE;
          end else if (dbg_valid) begin
            grant = GNT_DBG;
          end
        end
        HALT:    grant = GNT_DBG;
        default: grant = GNT_NONE;
      endcase
    end
  end

  assign core_go    = (grant == GNT_CORE);
  assign dbg_ready  = (grant == GNT_DBG);
  assign dbg_go     = dbg_ready && dbg_valid;
  assign core_stall = rst && core_req && !core_go;

  assign mem_en    = core_go || dbg_go;
  assign mem_we    = core_go ? core_we : (dbg_go && dbg_we);
  assign mem_addr  = core_go ? core_addr  : (dbg_go ? dbg_addr  : '0);
  assign mem_wdata = core_go ? core_wdata : (dbg_go ? dbg_wdata : '0);

  assign dbg_halt_ack = (state_reg == HALT);
  assign dbg_rvalid   = dbg_rd_pend_reg;

  // Read data passes straight through in the return cycle, then is held.
  assign core_rdata = core_rd_pend_reg ? mem_rdata : core_rdata_reg;
  assign dbg_rdata  = dbg_rd_pend_reg  ? mem_rdata : dbg_rdata_reg;

  mips_16_arb_starve_cnt #(
    .MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!dbg_valid || dbg_ready),
    .inc   (dbg_valid && !dbg_ready),
    .at_max(starve_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= SHARE;
      core_rd_pend_reg <= 1'b0;
      dbg_rd_pend_reg  <= 1'b0;
      core_rdata_reg   <= '0;
      dbg_rdata_reg    <= '0;
    end else begin
      core_rd_pend_reg <= core_go && !core_we;
      dbg_rd_pend_reg  <= dbg_go && !dbg_we;
      if (core_rd_pend_reg) core_rdata_reg <= mem_rdata;
      if (dbg_rd_pend_reg)  dbg_rdata_reg  <= mem_rdata;

      // DRAIN lasts one cycle so a read granted just before it can return.
      case (state_reg)
        SHARE:   state_reg <= dbg_halt_req ? DRAIN : SHARE;
        DRAIN:   state_reg <= dbg_halt_req ? HALT  : SHARE;
        HALT:    state_reg <= dbg_halt_req ? HALT  : SHARE;
        default: state_reg <= SHARE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_16_dmem_arbiter.sv
// Randomized scoreboard bench for mips_16_dmem_arbiter against a behavioural model.
module tb_mips_16_dmem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic          dbg_valid = 1'b0, dbg_we = 1'b0;
  logic          dbg_ready;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_halt_req = 1'b0;
  logic          dbg_halt_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mips_16_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_halt_req(dbg_halt_req), .dbg_halt_ack(dbg_halt_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Backing memory with one-cycle read latency
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          core_q[$];
  exp_t          dbg_q[$];
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] exp_core_last = '0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  bit            run = 1'b0;

  // Model state: 0 = sharing, 1 = draining, 2 = halted
  int   mode = 0;
  int   starve = 0;
  logic last_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; expectations come from the model state above.
  task automatic step(input logic cr, input logic cwe, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cwd, input logic dv, input logic dwe,
                      input logic [AW-1:0] da, input logic [DW-1:0] dwd, input logic hr);
    logic core_gnt, dbg_rdy, dbg_xfer;
    @(posedge clk);
    #1;
    core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
    dbg_valid = dv; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    dbg_halt_req = hr;
    core_gnt = (mode == 0) && cr && !(dv && starve == SMAX);
    dbg_rdy  = (mode == 2) || ((mode == 0) && dv && (!cr || starve == SMAX));
    dbg_xfer = dbg_rdy && dv;
    @(negedge clk);
    chk("core_stall", core_stall, cr && !core_gnt);
    chk("dbg_ready", dbg_ready, dbg_rdy);
    chk("dbg_halt_ack", dbg_halt_ack, mode == 2);
    chk("mem_en", mem_en, core_gnt || dbg_xfer);
    if (core_gnt) begin
      chk("mem_we", mem_we, cwe);
      chk("mem_addr", mem_addr, ca);
      if (cwe) shadow[ca] = cwd;
      else core_q.push_back('{cyc + 1, shadow[ca]});
      $display("core %s a=%h d=%h cyc=%0d", cwe ? "wr" : "rd", ca, cwe ? cwd : shadow[ca], cyc);
    end else if (dbg_xfer) begin
      chk("mem_we", mem_we, dwe);
      chk("mem_addr", mem_addr, da);
      if (dwe) shadow[da] = dwd;
      else dbg_q.push_back('{cyc + 1, shadow[da]});
      $display("dbg %s a=%h d=%h cyc=%0d", dwe ? "wr" : "rd", da, dwe ? dwd : shadow[da], cyc);
    end
    last_stall = cr && !core_gnt;
    starve = (!dv || dbg_rdy) ? 0 : ((starve < SMAX) ? starve + 1 : SMAX);
    if (mode == 0)      mode = hr ? 1 : 0;
    else if (mode == 1) mode = hr ? 2 : 0;
    else                mode = hr ? 2 : 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst core_rdata", core_rdata, 0);
    chk("rst core_stall", core_stall, 0);
    chk("rst dbg_ready", dbg_ready, 0);
    chk("rst dbg_rvalid", dbg_rvalid, 0);
    chk("rst dbg_rdata", dbg_rdata, 0);
    chk("rst dbg_halt_ack", dbg_halt_ack, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
  endtask

  // Reset asserted just after a clock edge, held for two cycles.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    core_req = 1'b1; core_we = 1'b0; dbg_valid = 1'b1; dbg_we = 1'b0; dbg_halt_req = 1'b0;
    core_q.delete();
    dbg_q.delete();
    exp_core_last = '0;
    mode = 0;
    starve = 0;
    last_stall = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    core_req = 1'b0; dbg_valid = 1'b0;
  endtask

  // Monitor: pops expected read returns when the DUT presents them.
  always @(negedge clk) begin
    if (run) begin
      if (core_q.size() > 0 && core_q[0].cyc == cyc) begin
        exp_core_last = core_q[0].data;
        void'(core_q.pop_front());
        $display("core rdata ret=%h cyc=%0d", core_rdata, cyc);
      end
      chk("core_rdata", core_rdata, exp_core_last);
      if (dbg_rvalid) begin
        if (dbg_q.size() > 0 && dbg_q[0].cyc == cyc) begin
          chk("dbg_rdata", dbg_rdata, dbg_q[0].data);
          void'(dbg_q.pop_front());
          $display("dbg rdata ret=%h cyc=%0d", dbg_rdata, cyc);
        end else begin
          chk("dbg_rvalid spurious", dbg_rvalid, 0);
        end
      end else if (dbg_q.size() > 0 && dbg_q[0].cyc == cyc) begin
        chk("dbg_rvalid missing", dbg_rvalid, 1);
        void'(dbg_q.pop_front());
      end
    end
  end

  initial begin
    logic          cr, cwe, dv, dwe, hr;
    logic [AW-1:0] ca, da;
    logic [DW-1:0] cwd, dwd;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = DW'($urandom);
      shadow[i] = mem[i];
    end
    mem[8'h20]    = 16'hBEEF;
    shadow[8'h20] = 16'hBEEF;

    run = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Core store then load of the same word
    step(1, 1, 8'h10, 16'h1234, 0, 0, 0, 0, 0);
    step(1, 0, 8'h10, 16'h0000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1 core_rdata", core_rdata, 16'h1234);

    // Core and debug both saturating: debug wins every fifth cycle
    for (int i = 0; i < 15; i++) step(1, 0, 8'h11, 0, 1, 0, 8'h12, 0, 0);

    // Idle core, debug read of the preloaded word
    step(0, 0, 0, 0, 1, 0, 8'h20, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3 dbg_rdata", dbg_rdata, 16'hBEEF);

    // Core load with halt request, drain, halted burst, release
    step(1, 0, 8'h10, 0, 0, 0, 0, 0, 1);
    step(1, 0, 8'h10, 0, 0, 0, 0, 0, 1);
    step(1, 0, 8'h10, 0, 1, 1, 8'h30, 16'hCAFE, 1);
    step(1, 0, 8'h10, 0, 1, 0, 8'h30, 0, 0);
    step(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset the cycle after a debug read grant: no read data may follow
    step(0, 0, 0, 0, 1, 0, 8'h20, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5 dbg_rvalid", dbg_rvalid, 0);

    // One-cycle halt pulse: drain then straight back to sharing
    step(1, 0, 8'h40, 0, 0, 0, 0, 0, 1);
    step(1, 0, 8'h40, 0, 1, 0, 8'h41, 0, 0);
    step(1, 1, 8'h42, 16'h5A5A, 1, 0, 8'h41, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic; a stalled core request is held unchanged
    cr = 0; cwe = 0; ca = 0; cwd = 0; hr = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        cr  = ($urandom_range(0, 3) != 0);
        cwe = $urandom_range(0, 1) == 1;
        ca  = AW'($urandom_range(0, 15));
        cwd = DW'($urandom);
      end
      dv  = ($urandom_range(0, 2) != 0);
      dwe = $urandom_range(0, 1) == 1;
      da  = AW'($urandom_range(0, 15));
      dwd = DW'($urandom);
      if ($urandom_range(0, 24) == 0) hr = ~hr;
      step(cr, cwe, ca, cwd, dv, dwe, da, dwd, hr);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("core_q drained", core_q.size(), 0);
    chk("dbg_q drained", dbg_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
